uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter among NUM_REQ byte producers.
- Sits between the producers and the transmitter/baud-generator pair, in the system clock domain.
- Holds the transmitter start as a level until the transmitter reports busy, so a slow baud-rate clock on the transmitter cannot miss it.
- Issues exactly one byte per grant.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width driven to the transmitter
START_TMO, 1024, system-clock cycles to wait for tx_busy before abort (timeout feature only)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  NUM_REQ*DATA_W  packed bytes; requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-cycle pulse: byte of requester i accepted
tx_data  output  DATA_W  byte to transmitter; stable from grant until return to IDLE
tx_start  output  1  level start request to transmitter
tx_busy  input  1  transmitter frame in progress
grant_id  output  $clog2(NUM_REQ)  index of last granted requester
arb_busy  output  1  high in any state other than IDLE
tmo_err  output  1  sticky start-timeout flag (0 when feature disabled)

Behaviour:
- One clock, clk. Reset is synchronous and active-high; only reset is sampled on the clk edge.
- Reset values:
  - req_ready=0, tx_start=0, tx_data=0, grant_id=0, arb_busy=0, tmo_err=0.
  - Round-robin pointer rr_ptr=0, state=IDLE.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; first set bit wins (g).
  - On a hit, at the next edge:
    - tx_data<=req_data[g], grant_id<=g;
    - req_ready[g]<=1 for exactly one cycle;
    - tx_start<=1, state<=WAIT_BUSY.
  - No hit: stay in IDLE, all outputs hold.
- WAIT_BUSY:
  - tx_start stays 1 until tx_busy is sampled 1.
  - Then tx_start<=0, state<=WAIT_DONE.
- WAIT_DONE:
  - On tx_busy sampled 0: state<=IDLE, rr_ptr<=(grant_id+1) mod NUM_REQ.
- Latency:
  - Valid seen in IDLE at cycle 0 → req_ready and tx_start high at cycle 1.
  - Minimum spacing between grants = 3 cycles + transmitter busy time.
- Handshake rules:
  - A requester must hold req_valid and req_data stable until its req_ready pulse.
  - req_valid deasserted while not granted is legal; no byte is lost or duplicated.
- Simultaneous requests: the pointer order decides the winner; every continuously valid requester is served within NUM_REQ grants.
- tx_busy already 1 while in IDLE (transmitter owned elsewhere): still grant; WAIT_BUSY exits on the first cycle.
- Reset mid-operation: immediate return to reset values.
  - The accepted byte is dropped.
  - The transmitter frame already started is not aborted by this block.
- arb_busy is combinationally equal to (state!=IDLE).
- At most one req_ready bit is set in any cycle.

Optional Feature:
- Macro: UART_ARB_START_TIMEOUT_EN.
- Enabled:
  - A counter runs in WAIT_BUSY.
  - If it reaches START_TMO with tx_busy still 0:
    - tx_start<=0, tmo_err<=1 (sticky until reset), state<=IDLE;
    - rr_ptr advances past the failed requester.
  - The dropped byte is not retried.
- Disabled:
  - No counter; WAIT_BUSY waits indefinitely.
  - tmo_err is tied 0.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum typedef (arb_state_t: IDLE, WAIT_BUSY, WAIT_DONE);
  - default constants for NUM_REQ, DATA_W, START_TMO.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: hit, index.
  - Reusable by later multi-source blocks.

Test Plan:
- Single request: req_valid=4'b0100, req_data[2]=8'hA5; tx_busy rises 5 cycles after tx_start and lasts 20 cycles → req_ready=4'b0100 for one cycle, tx_data=8'hA5, grant_id=2, tx_start high for exactly 5 cycles, arb_busy low one cycle after tx_busy falls.
- All four valid continuously, bytes 8'h10/11/12/13, after reset → grant order 0,1,2,3,0; exactly one req_ready pulse per frame.
- rr_ptr=3 with requesters 1 and 3 valid → requester 3 granted first, then 1.
- tx_busy held 1 during IDLE with req_valid=4'b0001 → grant at cycle 1, state WAIT_DONE at cycle 2, no further grant until tx_busy=0.
- Reset asserted in WAIT_DONE → next cycle all outputs at reset values, rr_ptr=0; the next request from requester 0 is granted normally.
- With UART_ARB_START_TIMEOUT_EN and START_TMO=16, tx_busy tied 0 → tx_start drops after 16 cycles, tmo_err=1 and stays 1, the next valid requester is then granted; without the macro, tx_start stays high indefinitely and tmo_err=0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_START_TMO = 1024;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: the first set request at or after rr_ptr wins,
// with the search wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               hit,
  output logic [IW-1:0]      index
);

  // Walk the offsets from farthest to nearest so the nearest match is written last.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        hit   = 1'b1;
        index = IW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional start timeout in WAIT_BUSY is enabled with UART_ARB_START_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int START_TMO = DEF_START_TMO
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        arb_busy,
  output logic                        tmo_err
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t          state_reg, state_next;
  logic [IW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]       grant_id_reg, grant_id_next;
  logic [DATA_W-1:0]   tx_data_reg, tx_data_next;
  logic [NUM_REQ-1:0]  req_ready_reg, req_ready_next;
  logic                tx_start_reg, tx_start_next;
  logic                pick_hit;
  logic [IW-1:0]       pick_idx;
  logic [IW-1:0]       ptr_after_grant;
  logic [DATA_W-1:0]   req_bytes [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_reg),
    .hit    (pick_hit),
    .index  (pick_idx)
  );

  assign ptr_after_grant = (int'(grant_id_reg) == NUM_REQ - 1) ? '0 : grant_id_reg + 1'b1;

`ifdef UART_ARB_START_TIMEOUT_EN
  localparam int TMO_W = $clog2(START_TMO + 1);

  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             tmo_err_reg, tmo_err_next;
  logic             tmo_hit;

  // Counts cycles spent in WAIT_BUSY; cleared whenever the FSM is elsewhere.
  assign tmo_cnt_next = (state_reg == WAIT_BUSY) ? tmo_cnt_reg + 1'b1 : '0;
  assign tmo_hit      = (tmo_cnt_reg == TMO_W'(START_TMO - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_reg <= '0;
      tmo_err_reg <= 1'b0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
      tmo_err_reg <= tmo_err_next;
    end
  end

  assign tmo_err = tmo_err_reg;
`else
  localparam int unused_start_tmo = START_TMO;
  assign tmo_err = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_id_next  = grant_id_reg;
    tx_data_next   = tx_data_reg;
    tx_start_next  = tx_start_reg;
    req_ready_next = '0;
`ifdef UART_ARB_START_TIMEOUT_EN
    tmo_err_next   = tmo_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_hit) begin
          tx_data_next   = req_bytes[pick_idx];
          grant_id_next  = pick_idx;
          req_ready_next = NUM_REQ'(1) << pick_idx;
          tx_start_next  = 1'b1;
          state_next     = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          tx_start_next = 1'b0;
          state_next    = WAIT_DONE;
        end
`ifdef UART_ARB_START_TIMEOUT_EN
        else if (tmo_hit) begin
          // The byte is abandoned; the pointer moves on as if it had been sent.
          tx_start_next = 1'b0;
          tmo_err_next  = 1'b1;
          rr_ptr_next   = ptr_after_grant;
          state_next    = IDLE;
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          rr_ptr_next = ptr_after_grant;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_id_reg  <= '0;
      tx_data_reg   <= '0;
      tx_start_reg  <= 1'b0;
      req_ready_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_id_reg  <= grant_id_next;
      tx_data_reg   <= tx_data_next;
      tx_start_reg  <= tx_start_next;
      req_ready_reg <= req_ready_next;
    end
  end

  assign req_ready = req_ready_reg;
  assign tx_data   = tx_data_reg;
  assign tx_start  = tx_start_reg;
  assign grant_id  = grant_id_reg;
  assign arb_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit bytes).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        tmo_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .START_TMO (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_tx_start"},  32'(tx_start),  32'h0);
    chk({tag, "_tx_data"},   32'(tx_data),   32'h0);
    chk({tag, "_grant_id"},  32'(grant_id),  32'h0);
    chk({tag, "_arb_busy"},  32'(arb_busy),  32'h0);
    chk({tag, "_tmo_err"},   32'(tmo_err),   32'h0);
  endtask

  // Ticks until a req_ready pulse appears (bounded), then checks the grant.
  task automatic expect_grant(input string tag, input int id, input logic [7:0] data);
    int n;
    n = 0;
    while (req_ready == 4'b0 && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_ready"},    32'(req_ready), 32'(4'b0001 << id));
    chk({tag, "_grant_id"}, 32'(grant_id),  32'(id));
    chk({tag, "_tx_data"},  32'(tx_data),   32'(data));
    chk({tag, "_tx_start"}, 32'(tx_start),  32'h1);
    $display("grant %s: id=%0d data=0x%02h ready=%b", tag, grant_id, tx_data, req_ready);
  endtask

  // Transmitter accepts the start at once and stays busy for busy_len cycles.
  task automatic serve(input string tag, input int busy_len);
    tx_busy = 1'b1;
    tick();
    chk({tag, "_start_drop"}, 32'(tx_start),  32'h0);
    chk({tag, "_one_pulse"},  32'(req_ready), 32'h0);
    repeat (busy_len - 1) tick();
    tx_busy = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'(arb_busy), 32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0;
    req_data  = 32'h0;
    tx_busy   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk_reset_state("rst");

    // Single request from requester 2.
    req_valid = 4'b0100;
    req_data  = 32'h00A5_0000;
    tick();
    chk("t1_ready", 32'(req_ready), 32'h4);
    chk("t1_data",  32'(tx_data),   32'hA5);
    chk("t1_gid",   32'(grant_id),  32'h2);
    chk("t1_busy",  32'(arb_busy),  32'h1);
    req_valid = 4'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t1_start_hi", 32'(tx_start), 32'h1);
      if (i == 1) chk("t1_ready_once", 32'(req_ready), 32'h0);
      if (i == 4) tx_busy = 1'b1;
      tick();
    end
    chk("t1_start_lo", 32'(tx_start), 32'h0);
    repeat (18) tick();
    chk("t1_data_hold", 32'(tx_data), 32'hA5);
    tx_busy = 1'b0;
    chk("t1_busy_before_fall", 32'(arb_busy), 32'h1);
    tick();
    chk("t1_busy_after_fall", 32'(arb_busy), 32'h0);
    chk("t1_data_idle", 32'(tx_data), 32'hA5);
    $display("t1 single request done");

    // All four continuously valid after reset: order 0,1,2,3,0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h1312_1110;
    expect_grant("t2_g0", 0, 8'h10);
    serve("t2_s0", 3);
    expect_grant("t2_g1", 1, 8'h11);
    serve("t2_s1", 3);
    expect_grant("t2_g2", 2, 8'h12);
    serve("t2_s2", 3);
    expect_grant("t2_g3", 3, 8'h13);
    serve("t2_s3", 3);
    expect_grant("t2_g4", 0, 8'h10);
    serve("t2_s4", 3);

    // Bring pointer to 3, then requesters 1 and 3 compete.
    req_valid = 4'b0100;
    req_data  = 32'h0012_0000;
    expect_grant("t3_pre", 2, 8'h12);
    req_valid = 4'b1010;
    req_data  = 32'h2300_2100;
    serve("t3_sp", 2);
    expect_grant("t3_first", 3, 8'h23);
    req_valid = 4'b0010;
    serve("t3_s3", 2);
    expect_grant("t3_second", 1, 8'h21);
    req_valid = 4'b0000;
    serve("t3_s1", 2);

    // Transmitter already busy while idle.
    tx_busy   = 1'b1;
    req_valid = 4'b0001;
    req_data  = 32'h0000_0044;
    tick();
    chk("t4_ready", 32'(req_ready), 32'h1);
    chk("t4_start", 32'(tx_start),  32'h1);
    tick();
    chk("t4_wait_done_start", 32'(tx_start), 32'h0);
    chk("t4_wait_done_busy",  32'(arb_busy), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_no_regrant", 32'(req_ready), 32'h0);
    end
    tx_busy = 1'b0;
    tick();
    chk("t4_idle", 32'(arb_busy), 32'h0);
    tick();
    chk("t4_regrant", 32'(req_ready), 32'h1);

    // Reset in WAIT_DONE, then pointer must be back at 0.
    tx_busy = 1'b1;
    tick();
    chk("t5_in_wait_done", 32'(tx_start), 32'h0);
    reset = 1'b1;
    tick();
    chk_reset_state("t5_rst");
    reset     = 1'b0;
    tx_busy   = 1'b0;
    req_valid = 4'b1001;
    req_data  = 32'h6600_0055;
    tick();
    chk("t5_ready", 32'(req_ready), 32'h1);
    chk("t5_data",  32'(tx_data),   32'h55);
    req_valid = 4'b1000;

    // Transmitter never answers the start.
`ifdef UART_ARB_START_TIMEOUT_EN
    repeat (15) tick();
    chk("t6_start_hi", 32'(tx_start), 32'h1);
    chk("t6_no_err",   32'(tmo_err),  32'h0);
    tick();
    chk("t6_start_lo", 32'(tx_start), 32'h0);
    chk("t6_err",      32'(tmo_err),  32'h1);
    chk("t6_idle",     32'(arb_busy), 32'h0);
    tick();
    chk("t6_next_ready", 32'(req_ready), 32'h8);
    chk("t6_next_data",  32'(tx_data),   32'h66);
    chk("t6_err_sticky", 32'(tmo_err),   32'h1);
`else
    repeat (40) tick();
    chk("t6_start_hold", 32'(tx_start), 32'h1);
    chk("t6_no_err",     32'(tmo_err),  32'h0);
    chk("t6_still_busy", 32'(arb_busy), 32'h1);
    chk("t6_no_grant",   32'(req_ready), 32'h0);
`endif
    $display("t6 start-timeout scenario done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
